// File: rtl/prbs_ber_checker.sv
// prbs_ber_checker
//
// Receive-side PRBS9 (x^9 + x^5 + 1) bit-error-rate checker. A local copy of
// the transmitter's generator runs in step with the received samples. The
// block finds the channel latency by trying every candidate delay over one
// window, locks onto the best one, and then counts compared bits and errors.
//
// Ports:
//   clock        system clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_enable     block enable; low freezes every register
//   i_valid      sample strobe, one cycle per symbol
//   i_data       received hard-decision bit, qualified by i_valid
//   i_restart    synchronous pulse; restarts acquisition from FILL
//   o_lock       high while locked
//   o_delay      selected delay, meaningful while o_lock is high
//   o_bit_count  bits compared while locked (saturates at all-ones)
//   o_err_count  bit errors seen while locked (frozen with o_bit_count)
//
// Optional feature macro: PRBS_BER_LOSS_OF_LOCK_EN
//   When defined, a per-window error accumulator runs while locked and a
//   window with more than LOL_THRESH errors sends the block back to SEARCH.
//   The LOL_THRESH parameter only exists in that build.
//
// NB_DELAY must be at least 2 and WIN_LEN a power of two of at least 2.

module prbs_ber_checker #(
  parameter int         NB_DELAY   = 5,
  parameter int         WIN_LEN    = 64,
  parameter int         NB_CNT     = 32,
  parameter logic [8:0] SEED       = 9'h1AA
`ifdef PRBS_BER_LOSS_OF_LOCK_EN
  ,
  parameter int         LOL_THRESH = 8
`endif
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_data,
  input  logic                i_restart,
  output logic                o_lock,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  localparam int NB_WIN  = $clog2(WIN_LEN);
  localparam int NB_ACC  = NB_WIN + 1;
  localparam int NB_TAPS = (2 ** NB_DELAY) - 1;

`ifdef PRBS_BER_LOSS_OF_LOCK_EN
  localparam logic [NB_ACC-1:0] LOL_LIMIT = NB_ACC'(LOL_THRESH);
`endif

  // SETTLE is the single clock between the last search sample and LOCK,
  // where the winning delay is transferred to o_delay.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    SETTLE = 2'd2,
    LOCK   = 2'd3
  } state_t;

  state_t              state;
  logic [8:0]          prbs;
  logic [NB_TAPS-1:0]  hist;
  logic [NB_TAPS:0]    taps;
  logic [NB_DELAY-1:0] cand;
  logic [NB_DELAY-1:0] best;
  logic [NB_DELAY-1:0] sel;
  logic [NB_WIN-1:0]   win_cnt;
  logic [NB_ACC-1:0]   acc;
  logic [NB_ACC-1:0]   min_err;
  logic [NB_ACC-1:0]   win_total;
  logic                accept;
  logic                err_bit;
  logic                win_last;

  // A sample coinciding with i_restart is dropped.
  assign accept    = i_valid & i_enable & ~i_restart;

  // taps[0] is the generator output before this sample's advance; taps[k] is
  // the output k accepted samples earlier.
  assign taps      = {hist, prbs[8]};
  assign sel       = (state == LOCK) ? o_delay : cand;
  assign err_bit   = i_data ^ taps[sel];

  // Window total including the current sample, so the final sample of a
  // window takes part in the decision made on its own edge.
  assign win_total = acc + {{(NB_ACC-1){1'b0}}, err_bit};
  assign win_last  = &win_cnt;

  // All state lives in one block. Restart is honoured even while disabled so
  // that a pulse is never lost; otherwise i_enable low freezes everything.
  // During FILL the cand counter doubles as the fill counter: it walks
  // 0..2^NB_DELAY-1 and wraps back to 0, which is exactly the first
  // candidate SEARCH needs.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= FILL;
      prbs        <= SEED;
      hist        <= '0;
      cand        <= '0;
      best        <= '0;
      min_err     <= '1;
      acc         <= '0;
      win_cnt     <= '0;
      o_lock      <= 1'b0;
      o_delay     <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (i_restart) begin
      state       <= FILL;
      prbs        <= SEED;
      hist        <= '0;
      cand        <= '0;
      best        <= '0;
      min_err     <= '1;
      acc         <= '0;
      win_cnt     <= '0;
      o_lock      <= 1'b0;
      o_delay     <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (i_enable) begin
      if (accept) begin
        prbs <= {prbs[7:0], prbs[8] ^ prbs[4]};
        hist <= {hist[NB_TAPS-2:0], prbs[8]};
      end

      case (state)
        FILL: begin
          if (accept) begin
            cand <= cand + 1'b1;
            if (&cand) begin
              state <= SEARCH;
            end
          end
        end

        SEARCH: begin
          if (accept) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_last) begin
              acc <= '0;
              // Strict compare: on a tie the earlier (smaller) delay stays.
              if (win_total < min_err) begin
                min_err <= win_total;
                best    <= cand;
              end
              cand <= cand + 1'b1;
              if (&cand) begin
                state <= SETTLE;
              end
            end else begin
              acc <= win_total;
            end
          end
        end

        SETTLE: begin
          state       <= LOCK;
          o_lock      <= 1'b1;
          o_delay     <= best;
          o_bit_count <= '0;
          o_err_count <= '0;
          acc         <= '0;
          win_cnt     <= '0;
        end

        LOCK: begin
          if (accept) begin
            // Both counters stop together once the bit count saturates,
            // so the error count can never overtake it.
            if (!(&o_bit_count)) begin
              o_bit_count <= o_bit_count + 1'b1;
              if (err_bit) begin
                o_err_count <= o_err_count + 1'b1;
              end
            end
`ifdef PRBS_BER_LOSS_OF_LOCK_EN
            // Taps and generator keep running, so a fresh search can start
            // straight away without refilling the delay line.
            win_cnt <= win_cnt + 1'b1;
            if (win_last) begin
              acc <= '0;
              if (win_total > LOL_LIMIT) begin
                state   <= SEARCH;
                cand    <= '0;
                min_err <= '1;
                o_lock  <= 1'b0;
              end
            end else begin
              acc <= win_total;
            end
`endif
          end
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_ber_checker.sv
// tb_prbs_ber_checker
//
// Drives a delayed PRBS9 stream (delay 7) into two checker instances, one with
// default counters and one with 4-bit counters, and compares their outputs
// with a sequence-level reference model.

module tb_prbs_ber_checker;

  localparam int DELAY = 7;
  localparam int ACQ   = 32 + 32 * 64;
  localparam int PER   = 511;

  logic        clock;
  logic        i_reset;
  logic        i_enable;
  logic        i_valid;
  logic        i_data;
  logic        i_restart;

  logic        o_lock;
  logic [4:0]  o_delay;
  logic [31:0] o_bit_count;
  logic [31:0] o_err_count;

  logic        lock4;
  logic [4:0]  delay4;
  logic [3:0]  bits4;
  logic [3:0]  errs4;

  logic        seq [0:PER-1];
  int          sample_idx;
  int          exp_bits;
  int          exp_errs;
  int          exp_bits4;
  int          exp_errs4;
  int          check_count;
  int          fail_count;

  prbs_ber_checker dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_restart   (i_restart),
    .o_lock      (o_lock),
    .o_delay     (o_delay),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  prbs_ber_checker #(.NB_CNT(4)) dut4 (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_restart   (i_restart),
    .o_lock      (lock4),
    .o_delay     (delay4),
    .o_bit_count (bits4),
    .o_err_count (errs4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after idle extra cycles.
  task automatic applyStimulus(input logic v, input logic d, input logic r,
                               input int idle);
    i_valid   = v;
    i_data    = d;
    i_restart = r;
    @(negedge clock);
    i_valid   = 1'b0;
    i_restart = 1'b0;
    repeat (idle) @(negedge clock);
  endtask

  // Sends the next transmitter bit (optionally inverted) and updates the model.
  task automatic sendBit(input logic flip, input int idle);
    logic d;
    if (sample_idx >= DELAY) d = seq[(sample_idx - DELAY) % PER];
    else                     d = 1'($urandom);
    applyStimulus(1'b1, d ^ flip, 1'b0, idle);
    if (sample_idx >= ACQ) begin
      exp_bits++;
      if (flip) exp_errs++;
      if (exp_bits4 < 15) begin
        exp_bits4++;
        if (flip) exp_errs4++;
      end
    end
    sample_idx++;
  endtask

  task automatic resetModel();
    sample_idx = 0;
    exp_bits   = 0;
    exp_errs   = 0;
    exp_bits4  = 0;
    exp_errs4  = 0;
  endtask

  initial begin
    logic [8:0] seed;
    int         frozen_bits;
    int         frozen_errs;

    check_count = 0;
    fail_count  = 0;

    // Transmitter sequence: first nine bits are the seed MSB first, then
    // out(n) = out(n-9) ^ out(n-5).
    seed = 9'h1AA;
    for (int j = 0; j < 9; j++) seq[j] = seed[8 - j];
    for (int j = 9; j < PER; j++) seq[j] = seq[j - 9] ^ seq[j - 5];

    i_reset   = 1'b1;
    i_enable  = 1'b1;
    i_valid   = 1'b0;
    i_data    = 1'b0;
    i_restart = 1'b0;
    resetModel();

    repeat (3) @(negedge clock);
    checkOutput("reset_lock",   32'(o_lock),   32'd0);
    checkOutput("reset_delay",  32'(o_delay),  32'd0);
    checkOutput("reset_bits",   o_bit_count,   32'd0);
    checkOutput("reset_errs",   o_err_count,   32'd0);
    i_reset = 1'b0;
    @(negedge clock);

    // Acquisition with one strobe every 8 cycles.
    for (int i = 0; i < ACQ - 1; i++) sendBit(1'b0, 7);
    checkOutput("lock_before_last", 32'(o_lock), 32'd0);
    sendBit(1'b0, 0);
    checkOutput("lock_at_last_edge", 32'(o_lock), 32'd0);
    @(negedge clock);
    checkOutput("lock_rise",       32'(o_lock),  32'd1);
    checkOutput("lock_delay",      32'(o_delay), 32'(DELAY));
    checkOutput("lock_bits_clear", o_bit_count,  32'd0);
    checkOutput("lock4_delay",     32'(delay4),  32'(DELAY));
    repeat (6) @(negedge clock);

    for (int i = 0; i < 1000; i++) sendBit(1'b0, 7);
    checkOutput("clean_bits",  o_bit_count, 32'(exp_bits));
    checkOutput("clean_errs",  o_err_count, 32'(exp_errs));
    checkOutput("clean_bits4", 32'(bits4),  32'(exp_bits4));
    checkOutput("clean_errs4", 32'(errs4),  32'(exp_errs4));

    // Every 100th bit inverted.
    for (int k = 1; k <= 1000; k++) sendBit(k % 100 == 0, 7);
    checkOutput("flip_bits", o_bit_count, 32'(exp_bits));
    checkOutput("flip_errs", o_err_count, 32'(exp_errs));

    // Random spacing and random sparse errors.
    for (int i = 0; i < 512; i++)
      sendBit($urandom_range(0, 31) == 0, $urandom_range(1, 6));
    checkOutput("rand_lock",  32'(o_lock),  32'd1);
    checkOutput("rand_delay", 32'(o_delay), 32'(DELAY));
    checkOutput("rand_bits",  o_bit_count,  32'(exp_bits));
    checkOutput("rand_errs",  o_err_count,  32'(exp_errs));

    // Disabled for 50 cycles with the strobe toggling.
    frozen_bits = exp_bits;
    frozen_errs = exp_errs;
    i_enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      i_valid = ~i_valid;
      i_data  = 1'($urandom);
      @(negedge clock);
    end
    i_valid  = 1'b0;
    i_enable = 1'b1;
    checkOutput("freeze_bits", o_bit_count, 32'(frozen_bits));
    checkOutput("freeze_errs", o_err_count, 32'(frozen_errs));
    checkOutput("freeze_lock", 32'(o_lock), 32'd1);
    for (int i = 0; i < 100; i++) sendBit(1'b0, 7);
    checkOutput("resume_bits", o_bit_count, 32'(exp_bits));
    checkOutput("resume_errs", o_err_count, 32'(exp_errs));

    // Restart together with a strobe; the transmitter restarts with it.
    applyStimulus(1'b1, 1'($urandom), 1'b1, 0);
    resetModel();
    checkOutput("restart_lock",  32'(o_lock), 32'd0);
    checkOutput("restart_bits",  o_bit_count, 32'd0);
    checkOutput("restart_errs",  o_err_count, 32'd0);
    checkOutput("restart_lock4", 32'(lock4),  32'd0);

    for (int i = 0; i < ACQ - 1; i++) sendBit(1'b0, $urandom_range(1, 3));
    checkOutput("relock_before_last", 32'(o_lock), 32'd0);
    sendBit(1'b0, 0);
    checkOutput("relock_at_last_edge", 32'(o_lock), 32'd0);
    @(negedge clock);
    checkOutput("relock_rise",  32'(o_lock),  32'd1);
    checkOutput("relock_delay", 32'(o_delay), 32'(DELAY));
    repeat (2) @(negedge clock);

    for (int i = 0; i < 40; i++) sendBit($urandom_range(0, 7) == 0, 2);
    checkOutput("relock_bits",  o_bit_count, 32'(exp_bits));
    checkOutput("relock_errs",  o_err_count, 32'(exp_errs));
    checkOutput("relock_bits4", 32'(bits4),  32'(exp_bits4));
    checkOutput("relock_errs4", 32'(errs4),  32'(exp_errs4));

    // Asynchronous reset in the middle of the high phase.
    @(posedge clock);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("async_lock",  32'(o_lock),  32'd0);
    checkOutput("async_delay", 32'(o_delay), 32'd0);
    checkOutput("async_bits",  o_bit_count,  32'd0);
    checkOutput("async_errs",  o_err_count,  32'd0);
    checkOutput("async_lock4", 32'(lock4),   32'd0);
    checkOutput("async_bits4", 32'(bits4),   32'd0);
    @(negedge clock);
    i_reset = 1'b0;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", check_count, fail_count);
    $finish;
  end

endmodule
